muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative sequencer for the RV32M multiply/divide operations. It sits beside the main ALU in the execute stage.
- The control path launches it for an M-extension instruction (op=0110011, funct7[0]=1). The pipeline holds EX until done.
- One shared shift/add/subtract datapath is reused over XLEN iterations, under a small FSM with start/busy/done handshake and flush support.

Parameters:
- XLEN, 32, operand/result width. The iteration counter is $clog2(XLEN)+1 bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  launch request, sampled on rising edge of clk
- funct3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- srca  input  XLEN  rs1 operand, captured when start is accepted
- srcb  input  XLEN  rs2 operand, captured when start is accepted
- flush  input  1  abort current operation (branch/jump flush of EX)
- busy  output  1  operation in progress; the pipeline stalls EX while busy|start
- done  output  1  one-cycle pulse: result valid this cycle
- result  output  XLEN  operation result; held until the next accepted start

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset: state=IDLE, busy=0, done=0, result=0, counter=0, internal registers=0.
- Start acceptance:
  - start is accepted only in IDLE or DONE (back-to-back allowed).
  - start in CALC or FIX is ignored.
- On acceptance:
  - latch funct3.
  - latch operand magnitudes: abs() for signed operands (MULH both; MULHSU srca only; DIV/REM both). Raw values otherwise.
  - record the result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - load counter=XLEN.
- Normal path timing (start high in cycle 0):
  - CALC in cycles 1..XLEN.
  - FIX in cycle XLEN+1.
  - DONE in cycle XLEN+2, with done=1 and result valid.
  - At XLEN=32, done is in cycle 34.
- Multiply in CALC: shift-add, 2*XLEN-bit accumulator, one multiplier bit per cycle, LSB first.
- Divide in CALC: restoring division, one quotient bit per cycle, MSB first. Partial remainder is XLEN+1 bits.
- FIX cycle:
  - apply two's-complement negation if the recorded sign is set.
  - select the low word (MUL) or high word (MULH*) of the product, or the quotient (DIV/DIVU) or remainder (REM/REMU).
  - register into result.
- Special cases are detected at acceptance, skip CALC/FIX, and go IDLE->DONE (done in cycle 1):
  - Divide by zero (srcb==0): DIV/DIVU result = all ones; REM/REMU result = srca.
  - Signed overflow (DIV/REM, srca=0x80000000, srcb=0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- busy is 1 in CALC and FIX, and 0 in IDLE and DONE.
- done is 1 only in DONE. DONE -> IDLE next cycle unless start is high, in which case it goes to CALC (or DONE for a special case).
- Flush:
  - flush=1 in any state forces IDLE next cycle with busy=0 and done=0. result keeps its prior value.
  - flush has priority over start in the same cycle; start is dropped.
  - flush in the DONE cycle: done still pulses that cycle; the EX flush discards it.
- Reset has priority over flush and start; reset mid-CALC aborts with no done.
- Operand inputs are don't-care after acceptance; changing srca/srcb during CALC must not affect result.
- No combinational path from inputs to done or busy. result is registered.

Test Plan:
- MUL: srca=7, srcb=0xFFFFFFFD, start in cycle 0 -> busy=1 cycles 1-33, done=1 in cycle 34 only, result=0xFFFFFFEB. MULHU with the same operands -> result=0x00000006.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU srca=0xFFFFFFFF, srcb=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD, and REM -7/2 -> 0xFFFFFFFF, issued back-to-back with start high in the DONE cycle. The second done is 34 cycles after the first.
- Special cases, each with done in cycle 1 and busy never 1:
  - DIVU 0x1234/0 -> 0xFFFFFFFF.
  - REMU 0x1234/0 -> 0x00001234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Flush and start while busy:
  - start DIV, flush=1 in cycle 10 -> busy=0 from cycle 11, no done ever, result unchanged.
  - new start in cycle 12 -> correct result in cycle 46.
  - start pulses in cycles 5 and 20 of an active op -> ignored, single done.
- Synchronous reset asserted in cycle 15 of a MUL -> cycle 16: busy=0, done=0, result=0. Operand changes during CALC do not alter the result.

Source files
------------

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// muldiv_seq_if : start/operand/result bundle between EX control and muldiv_seq
// Revision 1.0
// ============================================================================
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] srca;
  logic [XLEN-1:0] srcb;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, srca, srcb, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, srca, srcb, flush,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// muldiv_seq : iterative RV32M multiply/divide sequencer (shift-add / restoring)
// Revision 1.0
// ============================================================================
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_seq_if.slave   bus
);
  localparam int c_cnt_w = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;
  logic [c_cnt_w-1:0]  r_count;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_operand;
  logic [2:0]          r_op;
  logic                r_neg;

  // Operand conditioning at acceptance
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_neg_in;
  logic            w_div0;
  logic            w_ovf;
  logic [XLEN-1:0] w_special_res;

  always_comb begin
    w_is_div   = bus.funct3[2];
    w_a_signed = w_is_div ? ~bus.funct3[0]
                          : (bus.funct3[1:0] == 2'b01) || (bus.funct3[1:0] == 2'b10);
    w_b_signed = w_is_div ? ~bus.funct3[0] : (bus.funct3[1:0] == 2'b01);
    w_sa       = w_a_signed & bus.srca[XLEN-1];
    w_sb       = w_b_signed & bus.srcb[XLEN-1];
    w_mag_a    = w_sa ? (~bus.srca + 1'b1) : bus.srca;
    w_mag_b    = w_sb ? (~bus.srcb + 1'b1) : bus.srcb;
    w_neg_in   = (w_is_div && bus.funct3[1]) ? w_sa : (w_sa ^ w_sb);
    w_div0     = w_is_div && (bus.srcb == '0);
    w_ovf      = w_is_div && !bus.funct3[0]
                 && (bus.srca == {1'b1, {(XLEN-1){1'b0}}})
                 && (bus.srcb == {XLEN{1'b1}});
    if (w_div0)
      w_special_res = bus.funct3[1] ? bus.srca : {XLEN{1'b1}};
    else
      w_special_res = bus.funct3[1] ? '0 : bus.srca;
  end

  // Shared adder: hi-word accumulate for multiply, trial subtract for divide
  logic [XLEN+1:0]   w_opa;
  logic [XLEN+1:0]   w_opb;
  logic [XLEN+1:0]   w_sum;
  logic [2*XLEN-1:0] w_acc_next;

  always_comb begin
    w_opa = r_op[2] ? {1'b0, r_acc[2*XLEN-1:XLEN-1]} : {2'b00, r_acc[2*XLEN-1:XLEN]};
    w_opb = r_op[2] ? ~{2'b00, r_operand} : (r_acc[0] ? {2'b00, r_operand} : '0);
    w_sum = w_opa + w_opb + {{(XLEN+1){1'b0}}, r_op[2]};
    if (!r_op[2])
      w_acc_next = {w_sum[XLEN:0], r_acc[XLEN-1:1]};
    else if (w_sum[XLEN+1])
      w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
    else
      w_acc_next = {w_sum[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
  end

  // Sign fix-up: product negated as a whole before word select
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_word;
  logic [XLEN-1:0]   w_word_fix;
  logic [XLEN-1:0]   w_fixed;

  always_comb begin
    w_prod     = r_neg ? (~r_acc + 1'b1) : r_acc;
    w_word     = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    w_word_fix = r_neg ? (~w_word + 1'b1) : w_word;
    if (r_op[2])
      w_fixed = w_word_fix;
    else if (r_op[1:0] == 2'b00)
      w_fixed = w_prod[XLEN-1:0];
    else
      w_fixed = w_prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_count   <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
    end else if (bus.flush) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          if (bus.start) begin
            r_op      <= bus.funct3;
            r_neg     <= w_neg_in;
            r_count   <= c_cnt_w'(XLEN);
            r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_operand <= w_is_div ? w_mag_b : w_mag_a;
            if (w_div0 || w_ovf) begin
              r_result <= w_special_res;
              r_state  <= DONE;
              r_done   <= 1'b1;
            end else begin
              r_state <= CALC;
              r_busy  <= 1'b1;
            end
          end
        end
        CALC: begin
          r_acc   <= w_acc_next;
          r_count <= r_count - 1'b1;
          if (r_count == c_cnt_w'(1))
            r_state <= FIX;
        end
        FIX: begin
          r_result <= w_fixed;
          r_state  <= DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// tb_muldiv_seq : directed vector table plus multi-cycle corner sequences
// Revision 1.0
// ============================================================================
module tb_muldiv_seq;
  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic clk = 1'b0;
  logic reset;

  muldiv_seq_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.funct3 = f;
    bus.srca   = a;
    bus.srcb   = b;
    bus.start  = 1'b1;
  endtask

  // Counts cycles from launch until done; operands are scrambled meanwhile.
  task automatic wait_done(input int limit, output int cyc, output int nbusy);
    cyc   = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.start  = 1'b0;
      bus.srca   = $urandom;
      bus.srcb   = $urandom;
      bus.funct3 = 3'($urandom);
      if (bus.busy) nbusy++;
    end while (!bus.done && cyc < limit);
    if (!bus.done) cyc = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int cyc, nb, ndone, dcyc;

    vecs[0]  = '{F_MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 34};
    vecs[1]  = '{F_MULHU,  32'h00000007, 32'hFFFFFFFD, 32'h00000006, 34};
    vecs[2]  = '{F_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34};
    vecs[3]  = '{F_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vecs[4]  = '{F_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 34};
    vecs[5]  = '{F_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vecs[6]  = '{F_DIVU,   32'h00000064, 32'h00000007, 32'h0000000E, 34};
    vecs[7]  = '{F_REMU,   32'h00000064, 32'h00000007, 32'h00000002, 34};
    vecs[8]  = '{F_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 34};
    vecs[9]  = '{F_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 34};
    vecs[10] = '{F_DIVU,   32'h00001234, 32'h00000000, 32'hFFFFFFFF, 1};
    vecs[11] = '{F_REMU,   32'h00001234, 32'h00000000, 32'h00001234, 1};
    vecs[12] = '{F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vecs[13] = '{F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = '0;
    bus.srca   = '0;
    bus.srcb   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy",   32'(bus.busy), 32'd0);
    check("reset_done",   32'(bus.done), 32'd0);
    check("reset_result", bus.result,    32'd0);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      issue(vecs[i].f, vecs[i].a, vecs[i].b);
      wait_done(60, cyc, nb);
      check($sformatf("v%0d_done_cycle", i), 32'(cyc), 32'(vecs[i].lat));
      check($sformatf("v%0d_result", i), bus.result, vecs[i].exp);
      check($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(vecs[i].lat - 1));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
    end

    // Back-to-back DIV then REM, second start in the DONE cycle
    @(negedge clk);
    issue(F_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(60, cyc, nb);
    check("b2b_div_cycle",  32'(cyc), 32'd34);
    check("b2b_div_result", bus.result, 32'hFFFFFFFD);
    issue(F_REM, 32'hFFFFFFF9, 32'h00000002);
    wait_done(60, cyc, nb);
    check("b2b_rem_cycle",  32'(cyc), 32'd34);
    check("b2b_rem_result", bus.result, 32'hFFFFFFFF);

    // Flush in cycle 10, relaunch in cycle 12
    @(negedge clk);
    issue(F_DIV, 32'd1000, 32'd3);
    ndone = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) ndone++;
      if (k == 10) begin
        check("flush_busy_before", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
      end
      if (k == 11) begin
        bus.flush = 1'b0;
        check("flush_busy_after", 32'(bus.busy), 32'd0);
        check("flush_result_kept", bus.result, 32'hFFFFFFFF);
      end
      if (k == 12) issue(F_DIV, 32'd1000, 32'd3);
    end
    check("flush_no_done", 32'(ndone), 32'd0);
    wait_done(60, cyc, nb);
    check("relaunch_cycle",  32'(cyc + 12), 32'd46);
    check("relaunch_result", bus.result, 32'h0000014D);

    // Starts while busy are ignored
    @(negedge clk);
    issue(F_MUL, 32'h00001000, 32'h00000003);
    ndone = 0;
    dcyc  = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        ndone++;
        dcyc = k;
      end
      bus.start = (k == 5 || k == 20);
      if (bus.start) begin
        bus.funct3 = F_DIVU;
        bus.srca   = $urandom;
        bus.srcb   = 32'd0;
      end
    end
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_done_cycle", 32'(dcyc), 32'd34);
    check("ignore_result", bus.result, 32'h00003000);

    // Flush during the DONE cycle drops a simultaneous start
    @(negedge clk);
    issue(F_DIVU, 32'h00001234, 32'h00000000);
    @(negedge clk);
    check("flushdone_pulse", 32'(bus.done), 32'd1);
    bus.flush = 1'b1;
    issue(F_MUL, 32'd5, 32'd6);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    check("flushdone_done_after", 32'(bus.done), 32'd0);
    check("flushdone_busy_after", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("flushdone_start_dropped", 32'(bus.busy), 32'd0);
    check("flushdone_result", bus.result, 32'hFFFFFFFF);

    // Reset in cycle 15 of a MUL
    issue(F_MUL, 32'd5, 32'd6);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 15) reset = 1'b1;
    end
    @(negedge clk);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_result", bus.result,    32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("rst_no_done", 32'(ndone), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
